// File: rtl/riscv_pkg.sv
// Shared pipeline definitions: hazard FSM states and operand forward-select codes.
package riscv_pkg;

  typedef enum logic {
    StIdle,
    StMcBusy
  } hz_state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard unit signals. master = pipeline/MUL-DIV side, slave = hazard_ctrl.
interface hazard_ctrl_if #(
    parameter int unsigned REG_ADDR_W = 5
);
    logic [REG_ADDR_W-1:0] rs1D, rs2D;
    logic [REG_ADDR_W-1:0] rs1E, rs2E, rdE;
    logic                  ResultSrcE0;
    logic                  PCSrcE;
    logic [REG_ADDR_W-1:0] rdM, rdW;
    logic                  RegWriteM, RegWriteW;
    logic                  mc_reqE, mc_done;
    logic                  StallF, StallD, StallE;
    logic                  FlushD, FlushE, FlushM;
    logic [1:0]            ForwardAE, ForwardBE;
    logic                  mc_start;

    modport master (
        output rs1D, rs2D, rs1E, rs2E, rdE, ResultSrcE0, PCSrcE,
        output rdM, rdW, RegWriteM, RegWriteW, mc_reqE, mc_done,
        input  StallF, StallD, StallE, FlushD, FlushE, FlushM,
        input  ForwardAE, ForwardBE, mc_start
    );

    modport slave (
        input  rs1D, rs2D, rs1E, rs2E, rdE, ResultSrcE0, PCSrcE,
        input  rdM, rdW, RegWriteM, RegWriteW, mc_reqE, mc_done,
        output StallF, StallD, StallE, FlushD, FlushE, FlushM,
        output ForwardAE, ForwardBE, mc_start
    );
endinterface

// File: rtl/fwd_sel.sv
// Operand forward select for one Execute source: Memory beats Writeback, x0 never forwards.
module fwd_sel
    import riscv_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] rs_i,
    input  logic [REG_ADDR_W-1:0] rd_m_i,
    input  logic                  reg_write_m_i,
    input  logic [REG_ADDR_W-1:0] rd_w_i,
    input  logic                  reg_write_w_i,
    output logic [1:0]            fwd_o
);
    always_comb begin
        fwd_o = FWD_RF;
        if (reg_write_m_i && (rd_m_i != '0) && (rd_m_i == rs_i)) begin
            fwd_o = FWD_MEM;
        end else if (reg_write_w_i && (rd_w_i != '0) && (rd_w_i == rs_i)) begin
            fwd_o = FWD_WB;
        end
    end
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: MUL/DIV FSM, stall/flush priority, forwarding.
// Define HAZARD_PERF_CNT_EN to add the stall_cnt performance counter output.
module hazard_ctrl
    import riscv_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    hazard_ctrl_if.slave     hz
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt
`endif
);
    hz_state_e state_q, state_d;
    logic      mc_stall, load_use;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    assign load_use = hz.ResultSrcE0 && (hz.rdE != '0) &&
                      ((hz.rdE == hz.rs1D) || (hz.rdE == hz.rs2D));

    always_comb begin
        state_d     = state_q;
        mc_stall    = 1'b0;
        hz.mc_start = 1'b0;
        hz.StallF   = 1'b0;
        hz.StallD   = 1'b0;
        hz.StallE   = 1'b0;
        hz.FlushD   = 1'b0;
        hz.FlushE   = 1'b0;
        hz.FlushM   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (hz.mc_reqE && !hz.PCSrcE) begin
                    mc_stall    = 1'b1;
                    hz.mc_start = 1'b1;
                    state_d     = StMcBusy;
                end
            end
            StMcBusy: begin
                // Stalls release in the done cycle so the result advances on this edge.
                if (hz.mc_done) state_d = StIdle;
                else            mc_stall = 1'b1;
            end
            default: state_d = StIdle;
        endcase

        if (mc_stall) begin
            hz.StallF = 1'b1;
            hz.StallD = 1'b1;
            hz.StallE = 1'b1;
            hz.FlushM = 1'b1;
        end else if (hz.PCSrcE) begin
            hz.FlushD = 1'b1;
            hz.FlushE = 1'b1;
        end else if (load_use) begin
            hz.StallF = 1'b1;
            hz.StallD = 1'b1;
            hz.FlushE = 1'b1;
        end
    end

    fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
        .rs_i          (hz.rs1E),
        .rd_m_i        (hz.rdM),
        .reg_write_m_i (hz.RegWriteM),
        .rd_w_i        (hz.rdW),
        .reg_write_w_i (hz.RegWriteW),
        .fwd_o         (hz.ForwardAE)
    );

    fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
        .rs_i          (hz.rs2E),
        .rd_m_i        (hz.rdM),
        .reg_write_m_i (hz.RegWriteM),
        .rd_w_i        (hz.rdW),
        .reg_write_w_i (hz.RegWriteW),
        .fwd_o         (hz.ForwardBE)
    );

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    assign stall_cnt_d = hz.StallF ? stall_cnt_q + 1'b1 : stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cnt_q <= '0;
        else        stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed + random bench for hazard_ctrl against a rule-level reference model.
module tb_hazard_ctrl;
    localparam int unsigned CW = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    bit   busy_m = 1'b0;
    logic [CW-1:0] cnt_m = '0;

    hazard_ctrl_if #(.REG_ADDR_W(5)) hz ();

`ifdef HAZARD_PERF_CNT_EN
    logic [CW-1:0] stall_cnt;
    hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .hz        (hz),
        .stall_cnt (stall_cnt)
    );
`else
    hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );
`endif

    always #5 clk = ~clk;

    function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
        if (hz.RegWriteM && hz.rdM != 0 && hz.rdM == rs) return 2'b10;
        if (hz.RegWriteW && hz.rdW != 0 && hz.rdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    // {StallF,StallD,StallE,FlushD,FlushE,FlushM,mc_start,ForwardAE,ForwardBE}
    function automatic logic [10:0] model();
        bit mcs, start, lu, sf, sd, se, fd, fe, fm;
        start = !busy_m && hz.mc_reqE && !hz.PCSrcE;
        mcs   = busy_m ? !hz.mc_done : start;
        lu    = hz.ResultSrcE0 && hz.rdE != 0 && (hz.rdE == hz.rs1D || hz.rdE == hz.rs2D);
        {sf, sd, se, fd, fe, fm} = '0;
        if (mcs)            {sf, sd, se, fm} = '1;
        else if (hz.PCSrcE) {fd, fe} = '1;
        else if (lu)        {sf, sd, fe} = '1;
        return {sf, sd, se, fd, fe, fm, start, fwd_ref(hz.rs1E), fwd_ref(hz.rs2E)};
    endfunction

    function automatic logic [10:0] observed();
        return {hz.StallF, hz.StallD, hz.StallE, hz.FlushD, hz.FlushE, hz.FlushM,
                hz.mc_start, hz.ForwardAE, hz.ForwardBE};
    endfunction

    task automatic zero_inputs();
        {hz.rs1D, hz.rs2D, hz.rs1E, hz.rs2E, hz.rdE, hz.rdM, hz.rdW} = '0;
        {hz.ResultSrcE0, hz.PCSrcE, hz.RegWriteM, hz.RegWriteW, hz.mc_reqE, hz.mc_done} = '0;
    endtask

    task automatic check_vec(input string tag, input logic [10:0] exp);
        logic [10:0] obs;
        #1;
        obs = observed();
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
`ifdef HAZARD_PERF_CNT_EN
        checks++;
        assert (stall_cnt === cnt_m) else begin
            errors++;
            $error("FAIL %s_cnt observed=%0d expected=%0d", tag, stall_cnt, cnt_m);
        end
`endif
    endtask

    task automatic check(input string tag);
        check_vec(tag, model());
    endtask

    task automatic tick();
        logic [10:0] e;
        e = model();
        @(posedge clk);
        if (e[10]) cnt_m = cnt_m + 1'b1;
        if (!busy_m) busy_m = hz.mc_reqE && !hz.PCSrcE;
        else if (hz.mc_done) busy_m = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        zero_inputs();
        busy_m = 1'b0;
        cnt_m  = '0;
    endtask

    initial begin
        do_reset();
        @(negedge clk);
        check_vec("reset_all_zero", 11'b0);
        @(negedge clk);
        rst_n = 1'b1;
        check("idle_zero");
        tick();

        // Load-use on rs1D, then the bubble that FlushE leaves behind.
        hz.ResultSrcE0 = 1; hz.rdE = 5; hz.rs1D = 5;
        check_vec("load_use", 11'b11001000000);
        tick();
        zero_inputs();
        check_vec("load_use_after", 11'b0);
        tick();

        // Taken branch beats a simultaneous load-use.
        hz.PCSrcE = 1; hz.ResultSrcE0 = 1; hz.rdE = 7; hz.rs2D = 7;
        check_vec("branch_flush", 11'b00011000000);
        tick();
        zero_inputs();

        // DIV: one launch pulse, 10 stalled cycles, release in the done cycle.
        hz.mc_reqE = 1;
        check_vec("div_start", 11'b11100110000);
        tick();
        for (int i = 0; i < 10; i++) begin
            check_vec($sformatf("div_busy%0d", i), 11'b11100100000);
            tick();
        end
        hz.mc_done = 1;
        check_vec("div_done", 11'b0);
        tick();
        hz.mc_done = 0;
        check_vec("div_back_idle", 11'b11100110000);
        tick();
        hz.mc_reqE = 0; hz.mc_done = 1;
        check("div2_done");
        tick();
        zero_inputs();

        // Forwarding priority and x0.
        hz.RegWriteM = 1; hz.RegWriteW = 1; hz.rdM = 3; hz.rdW = 3; hz.rs1E = 3;
        check_vec("fwd_mem", 11'b00000001000);
        hz.rdM = 0;
        check_vec("fwd_wb", 11'b00000000100);
        hz.rs1E = 0; hz.rdW = 0;
        check_vec("fwd_x0", 11'b0);
        hz.rs2E = 3; hz.rdW = 3;
        check_vec("fwd_b_wb", 11'b00000000001);
        zero_inputs();
        tick();

        // Reset in the fourth busy cycle.
        hz.mc_reqE = 1;
        check("mid_start");
        tick();
        for (int i = 0; i < 3; i++) begin
            check("mid_busy");
            tick();
        end
        do_reset();
        check_vec("mid_reset_zero", 11'b0);
        @(negedge clk);
        rst_n = 1'b1;
        hz.mc_reqE = 1;
        check_vec("post_reset_idle", 11'b11100110000);
        tick();
        hz.mc_reqE = 0; hz.mc_done = 1;
        tick();
        zero_inputs();

        // Counter wrap: exactly 2**CW stall cycles from a fresh reset.
        do_reset();
        @(negedge clk);
        rst_n = 1'b1;
        hz.ResultSrcE0 = 1; hz.rdE = 9; hz.rs2D = 9;
        for (int i = 0; i < (1 << CW); i++) begin
            check("wrap_stall");
            tick();
        end
        zero_inputs();
`ifdef HAZARD_PERF_CNT_EN
        #1;
        checks++;
        assert (stall_cnt === '0) else begin
            errors++;
            $error("FAIL cnt_wrap observed=%0d expected=0", stall_cnt);
        end
`endif

        // Random traffic over a small register range so matches are frequent.
        for (int i = 0; i < 400; i++) begin
            hz.rs1D = 5'($urandom_range(0, 3)); hz.rs2D = 5'($urandom_range(0, 3));
            hz.rs1E = 5'($urandom_range(0, 3)); hz.rs2E = 5'($urandom_range(0, 3));
            hz.rdE  = 5'($urandom_range(0, 3)); hz.rdM  = 5'($urandom_range(0, 3));
            hz.rdW  = 5'($urandom_range(0, 3));
            hz.ResultSrcE0 = 1'($urandom);
            hz.PCSrcE      = ($urandom_range(0, 3) == 0);
            hz.RegWriteM   = 1'($urandom);
            hz.RegWriteW   = 1'($urandom);
            hz.mc_reqE     = ($urandom_range(0, 4) == 0) || busy_m;
            hz.mc_done     = busy_m && ($urandom_range(0, 3) == 0);
            check($sformatf("rand%0d", i));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have parameter REG_ADDR_W, default 5, giving the register-index width.
REQ-002 The block SHALL have parameter CNT_W, default 32, giving the stall-counter width.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset: asynchronous, active-low.
REQ-005 rs1D, rs2D  input  REG_ADDR_W  source registers of the instruction in Decode.
REQ-006 rs1E, rs2E, rdE  input  REG_ADDR_W  sources and destination of the instruction in Execute.
REQ-007 ResultSrcE0  input  1  high when the instruction in Execute is a load.
REQ-008 PCSrcE  input  1  high when a branch or jump in Execute is taken.
REQ-009 rdM, rdW  input  REG_ADDR_W  destinations in Memory and Writeback; RegWriteM, RegWriteW  input  1  write enables for those stages.
REQ-010 mc_reqE  input  1  high when Execute holds a multi-cycle MUL/DIV op; mc_done  input  1  one-cycle completion pulse from the unit.
REQ-011 StallF, StallD, StallE  output  1  hold the PC, IF/ID and ID/EX registers.
REQ-012 FlushD, FlushE, FlushM  output  1  zero IF/ID, ID/EX and EX/MEM on the next edge.
REQ-013 ForwardAE, ForwardBE  output  2  operand mux selects: 00 = register file, 01 = Writeback, 10 = Memory.
REQ-014 mc_start  output  1  one-cycle launch pulse to the multi-cycle unit.

Function
REQ-015 The FSM SHALL have two states, IDLE and MC_BUSY, held in one registered state variable.
REQ-016 IDLE to MC_BUSY: mc_reqE high and PCSrcE low; mc_start SHALL be 1 in that IDLE cycle only.
REQ-017 MC_BUSY to IDLE: mc_done high; MC_BUSY SHALL otherwise hold indefinitely, with no timeout.
REQ-018 mc_stall SHALL be (IDLE and mc_reqE and not PCSrcE) or (MC_BUSY and not mc_done).
- While mc_stall: StallF = StallD = StallE = 1 and FlushM = 1.
- In the mc_done cycle, stalls SHALL drop combinationally so the result advances on that edge.
REQ-019 Load-use condition: ResultSrcE0, rdE != 0, and rdE equal to rs1D or rs2D.
- Outside mc_stall, it SHALL assert StallF = StallD = FlushE = 1 for exactly one cycle per hazard.
REQ-020 PCSrcE high SHALL assert FlushD = FlushE = 1 and force StallF = StallD = 0.
- This applies even if a load-use hazard is also detected; flush wins.
REQ-021 Priority SHALL be mc_stall > PCSrcE > load-use.
- FlushD and FlushE SHALL be 0 while mc_stall is active.
REQ-022 ForwardAE SHALL be 10 if RegWriteM, rdM != 0 and rdM == rs1E.
- Otherwise 01 if RegWriteW, rdW != 0 and rdW == rs1E; otherwise 00.
- ForwardBE SHALL follow the same rule using rs2E.
REQ-023 Register x0 SHALL never cause a stall or a forward.
REQ-024 All outputs except the state and counter SHALL be combinational from the inputs and state.

Reset
REQ-025 rst_n low SHALL force state IDLE and counter 0 immediately, including in mid MC_BUSY.
- With all inputs low, every output SHALL read 0.
- The multi-cycle unit is reset by the same rst_n.

Configuration
REQ-026 With macro HAZARD_PERF_CNT_EN defined, the block SHALL add output stall_cnt, CNT_W wide.
- stall_cnt SHALL increment by 1 on every cycle where StallF = 1.
- It SHALL wrap from all-ones to 0 and reset to 0.
REQ-027 Without HAZARD_PERF_CNT_EN, the stall_cnt port and counter logic SHALL be absent; all other behaviour is identical.

Structure
REQ-028 Shared package riscv_pkg SHALL hold the FSM state encoding and the forward-select constants FWD_RF, FWD_WB and FWD_MEM.
REQ-029 The forwarding compare SHALL be a sub-module fwd_sel, instanced twice (operands A and B).
- hazard_ctrl SHALL keep the FSM, stall/flush logic and counter.

Verification
REQ-030 Load-use: ResultSrcE0 = 1, rdE = 5, rs1D = 5 -> StallF = StallD = FlushE = 1 for one cycle, then all 0.
REQ-031 Branch: PCSrcE = 1 together with a load-use on rdE = 7, rs2D = 7 -> FlushD = FlushE = 1, StallF = StallD = 0.
REQ-032 DIV: mc_reqE = 1 -> mc_start pulses once.
- Stalls and FlushM stay 1 for 10 cycles until mc_done.
- In the mc_done cycle stalls are 0; the next state is IDLE.
REQ-033 Forward: RegWriteM = RegWriteW = 1, rdM = rdW = rs1E = 3 -> ForwardAE = 10; with rdM = 0 -> 01; with rs1E = 0 -> 00.
REQ-034 Reset mid-op: rst_n low in MC_BUSY cycle 4 -> state IDLE and all outputs 0 immediately.
- With HAZARD_PERF_CNT_EN, stall_cnt reads 0 after reset; from all-ones, one more stall cycle wraps it to 0.
